// File: rtl/departure_sequencer_pkg.sv
// Shared airlock definitions: sequencer state encodings, default pressure thresholds and widths.
// The arrival sequencer imports the same package.
package departure_sequencer_pkg;

   localparam int PRESS_W = 8;
   localparam int CNT_W   = 16;

   localparam logic [PRESS_W-1:0] P_HIGH_DEF = 8'd80;
   localparam logic [PRESS_W-1:0] P_LOW_DEF  = 8'd5;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      PRESSURIZE   = 3'd1,
      WAIT_ENTRY   = 3'd2,
      DEPRESSURIZE = 3'd3,
      SETTLE       = 3'd4,
      WAIT_EXIT    = 3'd5
   } seqState_t;

   function automatic logic doorsSealed(input logic idClosed, input logic odClosed);
      return idClosed && odClosed;
   endfunction

endpackage

// File: rtl/departure_sequencer_timer.sv
// seq_timer: 16-bit saturating cycle counter with synchronous clear and a terminal-count compare.
// One instance serves both the entry timeout and the post-depressurize settle delay.
module seq_timer
   import departure_sequencer_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] termCount,
   output logic             atTerm
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

   assign atTerm = (count == termCount);

endmodule

// File: rtl/departure_sequencer.sv
// Departure sequencer: pressurize, admit occupant, seal, evacuate, settle, release outer door.
// Optional abort input enabled by defining DEPARTURE_ABORT_EN.
module departure_sequencer
   import departure_sequencer_pkg::*;
#(
   parameter logic [PRESS_W-1:0] P_HIGH       = P_HIGH_DEF,
   parameter logic [PRESS_W-1:0] P_LOW        = P_LOW_DEF,
   parameter int unsigned        SETTLE_CYC   = 8,
   parameter int unsigned        ENTRY_TO_CYC = 1000
)(
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic               in_chamber,
   input  logic               id_closed,
   input  logic               od_closed,
   input  logic [PRESS_W-1:0] pressure,
`ifdef DEPARTURE_ABORT_EN
   input  logic               abort,
`endif
   output logic               busy,
   output logic               start_pressurizing,
   output logic               start_depressurizing,
   output logic               forceDoors,
   output logic               done,
   output logic               timeout
);

   seqState_t        state, nextState;
   logic             sealed, pressHigh, pressLow, abortReq;
   logic             atTerm, timerClear, timerEnable;
   logic [CNT_W-1:0] termCount;
   logic             busyNxt, spNxt, sdNxt, forceNxt, doneNxt, timeoutNxt;

   assign sealed    = doorsSealed(id_closed, od_closed);
   assign pressHigh = pressure > P_HIGH;
   assign pressLow  = pressure < P_LOW;

`ifdef DEPARTURE_ABORT_EN
   assign abortReq = abort;
`else
   assign abortReq = 1'b0;
`endif

   // Counter restarts on every state change so each timed state begins at zero.
   assign timerClear  = (nextState != state);
   assign timerEnable = (state == WAIT_ENTRY) || (state == SETTLE);
   assign termCount   = (state == SETTLE) ? CNT_W'(SETTLE_CYC - 1) : CNT_W'(ENTRY_TO_CYC - 1);

   seq_timer uTimer (
      .clock     (clock),
      .reset     (reset),
      .clear     (timerClear),
      .enable    (timerEnable),
      .termCount (termCount),
      .atTerm    (atTerm)
   );

   always_comb begin
      nextState  = state;
      doneNxt    = 1'b0;
      timeoutNxt = 1'b0;
      case (state)
         IDLE:         if (start) nextState = pressHigh ? WAIT_ENTRY : PRESSURIZE;
         PRESSURIZE: begin
            if (abortReq)       nextState = IDLE;
            else if (pressHigh) nextState = WAIT_ENTRY;
         end
         WAIT_ENTRY: begin
            if (abortReq)                   nextState = IDLE;
            else if (in_chamber && sealed)  nextState = DEPRESSURIZE;
            else if (atTerm) begin
               nextState  = IDLE;
               timeoutNxt = 1'b1;
            end
         end
         DEPRESSURIZE: if (pressLow) nextState = SETTLE;
         SETTLE:       if (atTerm) nextState = WAIT_EXIT;
         WAIT_EXIT: begin
            if (!in_chamber && od_closed) begin
               nextState = IDLE;
               doneNxt   = 1'b1;
            end
         end
         default:      nextState = IDLE;
      endcase

      // Outputs are registered images of the state being entered.
      busyNxt  = (nextState != IDLE);
      forceNxt = (nextState inside {PRESSURIZE, DEPRESSURIZE, SETTLE});
      spNxt    = (nextState == PRESSURIZE) && sealed;
      sdNxt    = (nextState == DEPRESSURIZE) && sealed;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state                <= IDLE;
         busy                 <= 1'b0;
         start_pressurizing   <= 1'b0;
         start_depressurizing <= 1'b0;
         forceDoors           <= 1'b0;
         done                 <= 1'b0;
         timeout              <= 1'b0;
      end else begin
         state                <= nextState;
         busy                 <= busyNxt;
         start_pressurizing   <= spNxt;
         start_depressurizing <= sdNxt;
         forceDoors           <= forceNxt;
         done                 <= doneNxt;
         timeout              <= timeoutNxt;
      end
   end

   pressureCmdExclusive: assert property (@(posedge clock) disable iff (!reset)
      !(start_pressurizing && start_depressurizing));

endmodule

// File: tb/tb_departure_sequencer.sv
// Directed bench for departure_sequencer: vector table for the main sequence, hand-written
// sequences for door interruption, entry timeout, entry/timeout tie and asynchronous reset.
module tb_departure_sequencer;

   logic       clock = 1'b0;
   logic       reset, start, in_chamber, id_closed, od_closed, abort;
   logic [7:0] pressure;
   logic       busy, start_pressurizing, start_depressurizing, forceDoors, done, timeout;

   int vectors     = 0;
   int miscompares = 0;

   // Expected output word order: {busy, start_pressurizing, start_depressurizing, force, done, timeout}
   typedef struct {
      logic       st;
      logic       inCh;
      logic       idC;
      logic       odC;
      logic [7:0] press;
      logic [5:0] expOut;
      string      name;
   } vec_t;

   vec_t tbl[21];

   always #5 clock = ~clock;

   departure_sequencer #(
      .SETTLE_CYC   (8),
      .ENTRY_TO_CYC (10)
   ) dut (
      .clock                (clock),
      .reset                (reset),
      .start                (start),
      .in_chamber           (in_chamber),
      .id_closed            (id_closed),
      .od_closed            (od_closed),
      .pressure             (pressure),
`ifdef DEPARTURE_ABORT_EN
      .abort                (abort),
`endif
      .busy                 (busy),
      .start_pressurizing   (start_pressurizing),
      .start_depressurizing (start_depressurizing),
      .forceDoors           (forceDoors),
      .done                 (done),
      .timeout              (timeout)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic setIn(input logic st, input logic ic, input logic idc, input logic odc,
                        input logic [7:0] p);
      start      = st;
      in_chamber = ic;
      id_closed  = idc;
      od_closed  = odc;
      pressure   = p;
   endtask

   task automatic check(input string name, input logic [5:0] expOut);
      logic [5:0] act;
      act = {busy, start_pressurizing, start_depressurizing, forceDoors, done, timeout};
      vectors++;
      if (act !== expOut) begin
         miscompares++;
         $display("FAIL %s: got %b expected %b", name, act, expOut);
      end
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd90, 6'b100000, "t1_wait_entry"};
      tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd90, 6'b101100, "t3_depress"};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'd50, 6'b101100, "t3_start_ignored"};
      tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd4,  6'b100100, "t3_settle_enter"};
      for (int i = 4; i <= 10; i++)
         tbl[i] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd4, 6'b100100, "t3_settle_hold"};
      tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd4,  6'b100000, "t3_wait_exit"};
      tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd4,  6'b100000, "t3_still_inside"};
      tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd4,  6'b000010, "t3_done_pulse"};
      tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd4,  6'b000000, "t3_done_clear"};
      tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd40, 6'b110100, "t2_pressurize"};
      tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd60, 6'b100100, "t2_inner_open"};
      tbl[17] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd60, 6'b110100, "t2_reclosed"};
      tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd80, 6'b110100, "t2_at_p_high"};
      tbl[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd81, 6'b100000, "t2_wait_entry"};
      tbl[20] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd81, 6'b101100, "t2_entered"};

      abort = 1'b0;
      reset = 1'b0;
      setIn(1'b0, 1'b0, 1'b1, 1'b1, 8'd0);
      step();
      check("reset_state", 6'b000000);
      reset = 1'b1;
      step();
      check("idle_no_start", 6'b000000);

      for (int i = 0; i < 21; i++) begin
         setIn(tbl[i].st, tbl[i].inCh, tbl[i].idC, tbl[i].odC, tbl[i].press);
         step();
         check(tbl[i].name, tbl[i].expOut);
      end

      // Inner door opens mid-evacuation: command drops, state held, then resumes.
      setIn(1'b0, 1'b1, 1'b0, 1'b1, 8'd50);
      step();
      check("t4_door_open", 6'b100100);
      step();
      check("t4_door_open_hold", 6'b100100);
      id_closed = 1'b1;
      step();
      check("t4_resume", 6'b101100);
      pressure = 8'd5;
      step();
      check("t4_p_low_strict", 6'b101100);
      pressure = 8'd4;
      step();
      check("t4_settle", 6'b100100);
      for (int i = 0; i < 7; i++) begin
         step();
         check("t4_settle_hold", 6'b100100);
      end
      step();
      check("t4_wait_exit", 6'b100000);
      in_chamber = 1'b0;
      step();
      check("t4_done", 6'b000010);

      // Entry timeout after 10 cycles in WAIT_ENTRY.
      setIn(1'b1, 1'b0, 1'b1, 1'b1, 8'd90);
      step();
      check("t5_wait_entry", 6'b100000);
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         step();
         check("t5_waiting", 6'b100000);
      end
      step();
      check("t5_timeout", 6'b000001);
      step();
      check("t5_timeout_clear", 6'b000000);

      // Entry on the terminal cycle wins over timeout.
      start = 1'b1;
      step();
      check("tie_wait_entry", 6'b100000);
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         step();
         check("tie_waiting", 6'b100000);
      end
      in_chamber = 1'b1;
      step();
      check("tie_entry_wins", 6'b101100);

      // Asynchronous reset mid-DEPRESSURIZE, start held during reset.
      pressure = 8'd50;
      #2;
      reset = 1'b0;
      start = 1'b1;
      #1;
      check("t6_async_reset", 6'b000000);
      step();
      check("t6_start_in_reset", 6'b000000);
      reset = 1'b1;
      start = 1'b0;
      step();
      check("t6_idle_after_reset", 6'b000000);
      setIn(1'b1, 1'b0, 1'b1, 1'b1, 8'd90);
      step();
      check("t6_restart", 6'b100000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
